// File: rtl/axi_write_burst.sv
// Stream-to-AXI4 write burst master: buffers AW_LEN stream beats, then issues one INCR burst.
// Optional macro AXI_WR_BYTE_SWAP_EN byte-reverses each 32-bit lane on entry to the buffer.
module axi_write_burst #(
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    DATA_WIDTH       = 64,
  parameter int                    AW_LEN           = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                    BURSTS_PER_FRAME = 16
) (
  input  logic                    M_WR_aclk,
  input  logic                    M_WR_aresetn,

  input  logic                    S_WR_tvalid,
  input  logic [DATA_WIDTH-1:0]   S_WR_tdata,
  output logic                    S_WR_tready,

  output logic                    o_wr_done,
  output logic                    o_bresp_err,

  output logic                    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic                    m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int CNT_W = (AW_LEN > 1) ? $clog2(AW_LEN) : 1;
  localparam int BI_W  = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;

  localparam logic [CNT_W-1:0]      FIRST_BEAT  = '0;
  localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(AW_LEN - 1);
  localparam logic [BI_W-1:0]       LAST_BURST  = BI_W'(BURSTS_PER_FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(AW_LEN * (DATA_WIDTH / 8));
  localparam logic [1:0]            RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    FILL,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      beat_next;
  logic [BI_W-1:0]       burst_idx;
  logic                  fill_beat;
  logic [DATA_WIDTH-1:0] buffer [AW_LEN];

  // Bursts always use the same ID, so the returned bid carries no information.
  logic unused_bid;
  assign unused_bid = m_axi_bid;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = 8'(AW_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wstrb   = '1;

  assign fill_beat = S_WR_tvalid && S_WR_tready;
  assign beat_next = beat_cnt + CNT_W'(1);

  function automatic logic [DATA_WIDTH-1:0] lane_swap(input logic [DATA_WIDTH-1:0] d);
`ifdef AXI_WR_BYTE_SWAP_EN
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int l = 0; l < DATA_WIDTH / 32; l++) begin
      for (int b = 0; b < 4; b++) begin
        r[l*32 + b*8 +: 8] = d[l*32 + (3-b)*8 +: 8];
      end
    end
    return r;
`else
    return d;
`endif
  endfunction

  // NOTE: the buffer has no reset; beat_cnt restarts at 0 so stale entries are always overwritten before being read.
  always_ff @(posedge M_WR_aclk) begin
    if (fill_beat) begin
      buffer[beat_cnt] <= lane_swap(S_WR_tdata);
    end
  end

  // NOTE: outputs are registered, so each transition also loads the values the next state must present on its first cycle.
  always_ff @(posedge M_WR_aclk or negedge M_WR_aresetn) begin
    if (!M_WR_aresetn) begin
      state         <= FILL;
      beat_cnt      <= '0;
      burst_idx     <= '0;
      m_axi_awaddr  <= BASE_ADDR;
      S_WR_tready   <= 1'b1;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      o_wr_done     <= 1'b0;
      o_bresp_err   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fill_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt      <= '0;
              S_WR_tready   <= 1'b0;
              m_axi_awvalid <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              beat_cnt <= beat_next;
            end
          end
        end

        WR_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= buffer[FIRST_BEAT];
            m_axi_wlast   <= (AW_LEN == 1);
            state         <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              beat_cnt     <= '0;
              m_axi_bready <= 1'b1;
              state        <= WR_RESP;
            end else begin
              beat_cnt    <= beat_next;
              m_axi_wdata <= buffer[beat_next];
              m_axi_wlast <= (beat_next == LAST_BEAT);
            end
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            o_wr_done    <= 1'b1;
            if (m_axi_bresp != RESP_OKAY) begin
              o_bresp_err <= 1'b1;
            end
            state <= DONE;
          end
        end

        DONE: begin
          o_wr_done   <= 1'b0;
          S_WR_tready <= 1'b1;
          if (burst_idx == LAST_BURST) begin
            burst_idx    <= '0;
            m_axi_awaddr <= BASE_ADDR;
          end else begin
            burst_idx    <= burst_idx + BI_W'(1);
            m_axi_awaddr <= m_axi_awaddr + BURST_BYTES;
          end
          state <= FILL;
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/axi_write_burst.md
AXI_WRITE_BURST -- requirements
Module: axi_write_burst

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 64, data width (32/64/128); AW_LEN, 64, beats per burst (1..256); BASE_ADDR, 0, first burst address; BURSTS_PER_FRAME, 16, bursts before the address wraps.
REQ-002 M_WR_aclk  in  1  single clock for all logic and both the stream and AXI sides.
REQ-003 M_WR_aresetn  in  1  reset, asynchronous, active-low.
REQ-004 S_WR_tvalid in 1, S_WR_tdata in DATA_WIDTH, S_WR_tready out 1: upstream stream input.
REQ-005 o_wr_done  out  1  one-cycle pulse per completed burst; feeds the read stage's i_wr_done.
REQ-006 o_bresp_err  out  1  sticky flag: a nonzero bresp has been seen.
REQ-007 AXI write master ports SHALL be m_axi_awid, awaddr[ADDR_WIDTH], awlen[8], awsize[3], awburst[2], awlock, awcache[4], awprot[3], awqos[4], awvalid (out), awready (in), m_axi_wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], wlast, wvalid (out), wready (in), m_axi_bid, bresp[2], bvalid (in), bready (out).

Function
REQ-008 Constants SHALL be: awid=0, awlock=0, awcache=3, awprot=0, awqos=0, awburst=1 (INCR), awlen=AW_LEN-1, awsize=clog2(DATA_WIDTH/8), wstrb=all ones.
REQ-009 The FSM SHALL have states FILL, WR_ADDR, WR_DATA, WR_RESP and DONE, and SHALL enter FILL on reset.
REQ-010 FILL: S_WR_tready=1. Each tvalid&tready beat SHALL be written to an internal AW_LEN-entry buffer at index beat_cnt, and beat_cnt SHALL increment. On the beat with beat_cnt==AW_LEN-1, the FSM SHALL move to WR_ADDR and clear beat_cnt.
REQ-011 S_WR_tready SHALL be 0 in every state other than FILL; upstream stalls during the write.
REQ-012 WR_ADDR: awvalid SHALL be 1 from the first cycle in the state, with awaddr stable, until awready. On the awvalid&awready cycle the FSM SHALL move to WR_DATA and awvalid SHALL drop the next cycle.
REQ-013 WR_DATA: wvalid SHALL be 1, with wdata = buffer[beat_cnt] and wlast = (beat_cnt==AW_LEN-1). beat_cnt SHALL advance only on wvalid&wready, and wdata/wlast SHALL hold stable while wready=0. On the wlast handshake the FSM SHALL move to WR_RESP.
REQ-014 WR_RESP: bready SHALL be 1. On bvalid the FSM SHALL move to DONE. If bresp!=0, o_bresp_err SHALL set and stay set until reset.
REQ-015 DONE SHALL last exactly one cycle: o_wr_done=1, then advance the address, then return to FILL.
REQ-016 Address advance: awaddr SHALL increase by AW_LEN*DATA_WIDTH/8 per burst. After burst index BURSTS_PER_FRAME-1 it SHALL wrap to BASE_ADDR. Address arithmetic SHALL be modulo 2^ADDR_WIDTH.
REQ-017 AW_LEN=1: FILL SHALL accept exactly one beat, and wlast SHALL be 1 on the only W beat.
REQ-018 bvalid arriving in the same cycle the FSM enters WR_RESP SHALL be accepted in that cycle; the minimum WR_RESP dwell is 1 cycle.
REQ-019 Stream beats presented outside FILL SHALL not be consumed or lost; they remain pending on the upstream side.

Reset
REQ-020 Reset SHALL force state=FILL, beat_cnt=0, burst index=0, awaddr=BASE_ADDR, and drive awvalid=wvalid=wlast=bready=o_wr_done=o_bresp_err=0 and S_WR_tready=1 (first clock edge after release).
REQ-021 Reset asserted mid-burst SHALL abandon the burst immediately and discard buffer contents; no partial o_wr_done SHALL be produced.

Configuration
REQ-022 Macro AXI_WR_BYTE_SWAP_EN. When defined, each 32-bit lane of S_WR_tdata SHALL be byte-reversed on entry to the buffer (bytes 0..3 -> 3..0), matching the read stage's output swap so that end-to-end data is restored. When undefined, data SHALL be stored unmodified.

Verification
REQ-023 Continuous tvalid, 64 beats 0..63, awready/wready/bvalid tied high, no swap -> one AW at 0x0, 64 W beats 0..63 with wlast on beat 63, o_wr_done pulses once.
REQ-024 wready toggled 1/0 every cycle -> wdata/wlast held stable during stalls, 64 beats delivered in order, no duplicates.
REQ-025 16 consecutive bursts then a 17th -> awaddr 0x0, 0x200, ..., 0x1E00, then 0x0 (DATA_WIDTH=64, AW_LEN=64).
REQ-026 bresp=2 on burst 3 -> o_bresp_err=1 from that cycle and stays 1 through subsequent OKAY responses until reset.
REQ-027 AXI_WR_BYTE_SWAP_EN defined, input beat 0x1122334455667788 -> wdata 0x4433221188776655.
REQ-028 Reset pulled low at W beat 20 of a burst -> awvalid/wvalid drop, S_WR_tready=1. Next burst after release starts at BASE_ADDR with beat 0.
